// File: rtl/svm_dot_sched.sv
// svm_dot_sched: runs one test vector against up to NUM_SV stored support
// vectors. For each SV it reads the word from SV memory, hands it to the shared
// dot-product datapath, waits DP_LAT cycles, captures the score and offers it
// on a valid/ready result port. A one-cycle done pulse closes each run.
//
// Ports:
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_start, i_num_sv          run request and SV count, sampled only in IDLE
//   o_busy, o_done             run in progress / end-of-run pulse
//   o_sv_rd_en, o_sv_rd_addr   SV memory read; i_sv_rd_data valid 1 cycle later
//   o_dp_x_sv, o_dp_valid      SV vector to the datapath, update strobe
//   i_dp_result                datapath score
//   o_res_valid, i_res_ready   result handshake
//   o_res_data, o_res_idx      captured score and its SV index
//
// Optional feature (macro SVM_SCORE_MAX_EN):
//   o_max_data, o_max_idx      running maximum score of the run and its index
module svm_dot_sched #(
    parameter int unsigned XLEN_PIXEL    = 8,
    parameter int unsigned NUM_OF_PIXELS = 30,
    parameter int unsigned NUM_SV        = 16,
    parameter int unsigned SV_ADDR_W     = 4,
    parameter int unsigned ACC_W         = 32,
    parameter int unsigned DP_LAT        = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_start,
    input  logic [SV_ADDR_W:0]                  i_num_sv,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_sv_rd_en,
    output logic [SV_ADDR_W-1:0]                o_sv_rd_addr,
    input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] i_sv_rd_data,
    output logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0] o_dp_x_sv,
    output logic                                o_dp_valid,
    input  logic [ACC_W-1:0]                    i_dp_result,
    output logic                                o_res_valid,
    input  logic                                i_res_ready,
    output logic [ACC_W-1:0]                    o_res_data,
    output logic [SV_ADDR_W-1:0]                o_res_idx
`ifdef SVM_SCORE_MAX_EN
    ,
    output logic [ACC_W-1:0]                    o_max_data,
    output logic [SV_ADDR_W-1:0]                o_max_idx
`endif
);

    localparam int unsigned N_W   = SV_ADDR_W + 1;
    localparam int unsigned CNT_W = $clog2(DP_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [N_W-1:0]       r_n;
    logic [N_W-1:0]       w_n_clamp;
    logic [SV_ADDR_W-1:0] r_idx;
    logic [SV_ADDR_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic                 w_accept;
    logic                 w_hs;
    logic                 w_last;
    logic                 w_wait_end;

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_hs       = (r_state == S_EMIT) && i_res_ready;
    assign w_last     = ({1'b0, r_idx} == (r_n - N_W'(1)));
    assign w_wait_end = (r_state == S_WAIT) && (r_wait_cnt == CNT_W'(1));
    // Requests beyond the SV store are clamped so idx can never wrap.
    assign w_n_clamp  = (i_num_sv > N_W'(NUM_SV)) ? N_W'(NUM_SV) : i_num_sv;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-index logic.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = (i_num_sv == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_wait_end) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (i_res_ready) begin
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_idx_nxt   = r_idx + SV_ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, datapath registers and registered outputs. Control outputs
    // are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n          <= '0;
            r_idx        <= '0;
            r_wait_cnt   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_sv_rd_en   <= 1'b0;
            o_sv_rd_addr <= '0;
            o_dp_x_sv    <= '0;
            o_dp_valid   <= 1'b0;
            o_res_valid  <= 1'b0;
            o_res_data   <= '0;
            o_res_idx    <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            if (w_accept) begin
                r_n <= w_n_clamp;
            end
            if (r_state == S_LOAD) begin
                r_wait_cnt <= CNT_W'(DP_LAT);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - CNT_W'(1);
            end
            o_busy       <= (w_state_nxt inside {S_FETCH, S_LOAD, S_WAIT, S_EMIT});
            o_done       <= (w_state_nxt == S_FIN);
            o_sv_rd_en   <= (w_state_nxt == S_FETCH);
            o_sv_rd_addr <= w_idx_nxt;
            o_res_valid  <= (w_state_nxt == S_EMIT);
            // Memory data is valid in LOAD; the datapath sees it the cycle after.
            o_dp_valid   <= (r_state == S_LOAD);
            if (r_state == S_LOAD) begin
                o_dp_x_sv <= i_sv_rd_data;
            end
            if (w_wait_end) begin
                o_res_data <= i_dp_result;
                o_res_idx  <= r_idx;
            end
        end
    end

`ifdef SVM_SCORE_MAX_EN
    logic r_max_first;

    // Running maximum over accepted results; strict compare keeps the lower
    // index on ties, and the first result of a run always loads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_max_data  <= '0;
            o_max_idx   <= '0;
            r_max_first <= 1'b0;
        end else if (w_accept) begin
            o_max_data  <= '0;
            o_max_idx   <= '0;
            r_max_first <= 1'b1;
        end else if (w_hs) begin
            if (r_max_first || (o_res_data > o_max_data)) begin
                o_max_data <= o_res_data;
                o_max_idx  <= o_res_idx;
            end
            r_max_first <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_svm_dot_sched.sv
// tb_svm_dot_sched: directed and randomized runs of svm_dot_sched against
// a memory model, a datapath stand-in and an expected-result model built
// from the run request (scores, order, cycle timing, done, running max).
module tb_svm_dot_sched;

    localparam int unsigned XLEN_PIXEL    = 8;
    localparam int unsigned NUM_OF_PIXELS = 30;
    localparam int unsigned NUM_SV        = 16;
    localparam int unsigned SV_ADDR_W     = 4;
    localparam int unsigned ACC_W         = 32;
    localparam int unsigned DP_LAT        = 2;
    localparam int unsigned VEC_W         = NUM_OF_PIXELS * XLEN_PIXEL;
    localparam int unsigned N_W           = SV_ADDR_W + 1;
    localparam int          PERIOD        = DP_LAT + 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [N_W-1:0]       num_sv;
    logic                 busy, done, sv_rd_en, dp_valid, res_valid, res_ready;
    logic [SV_ADDR_W-1:0] sv_rd_addr, res_idx;
    logic [VEC_W-1:0]     sv_rd_data, dp_x_sv;
    logic [ACC_W-1:0]     dp_result, res_data;
`ifdef SVM_SCORE_MAX_EN
    logic [ACC_W-1:0]     max_data;
    logic [SV_ADDR_W-1:0] max_idx;
`endif

    svm_dot_sched #(
        .XLEN_PIXEL(XLEN_PIXEL), .NUM_OF_PIXELS(NUM_OF_PIXELS), .NUM_SV(NUM_SV),
        .SV_ADDR_W(SV_ADDR_W), .ACC_W(ACC_W), .DP_LAT(DP_LAT)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_sv(num_sv),
        .o_busy(busy), .o_done(done), .o_sv_rd_en(sv_rd_en), .o_sv_rd_addr(sv_rd_addr),
        .i_sv_rd_data(sv_rd_data), .o_dp_x_sv(dp_x_sv), .o_dp_valid(dp_valid),
        .i_dp_result(dp_result), .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_data(res_data), .o_res_idx(res_idx)
`ifdef SVM_SCORE_MAX_EN
        , .o_max_data(max_data), .o_max_idx(max_idx)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0  = 0;

    logic [VEC_W-1:0] mem [NUM_SV];
    int unsigned      xv  [NUM_OF_PIXELS];

    int q_res_cyc[$], q_res_idx[$], q_rd[$], q_busy[$], q_done[$];
    logic [ACC_W-1:0] q_res_data[$];
    logic [ACC_W-1:0]     done_max_data;
    logic [SV_ADDR_W-1:0] done_max_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] dot(input logic [VEC_W-1:0] v);
        int unsigned s;
        int unsigned pix;
        s = 0;
        for (int p = 0; p < NUM_OF_PIXELS; p++) begin
            pix = int'(v[p*XLEN_PIXEL +: XLEN_PIXEL]);
            s   = s + pix * xv[p];
        end
        return ACC_W'(s);
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        return VEC_W'({$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [VEC_W-1:0] splat(input int unsigned val);
        logic [VEC_W-1:0] v;
        for (int p = 0; p < NUM_OF_PIXELS; p++) v[p*XLEN_PIXEL +: XLEN_PIXEL] = XLEN_PIXEL'(val);
        return v;
    endfunction

    // SV memory: one-cycle read latency, junk when not read.
    always @(posedge clk) sv_rd_data <= sv_rd_en ? mem[sv_rd_addr] : rand_vec();

    // Datapath stand-in (DP_LAT = 2): the score of dp_x_sv appears the cycle
    // after dp_valid, the last cycle of the wait window, and is junk otherwise.
    always @(posedge clk) dp_result <= dp_valid ? dot(dp_x_sv) : 32'hDEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs events relative to the start cycle and checks that a
    // pending result is held unchanged until it is accepted.
    int                   rel;
    bit                   hold_pend = 1'b0;
    logic [ACC_W-1:0]     hold_data;
    logic [SV_ADDR_W-1:0] hold_idx;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            rel = cyc - t0;
            if (hold_pend) begin
                chk("hold_valid", 64'(res_valid), 64'd1);
                chk("hold_data",  64'(res_data),  64'(hold_data));
                chk("hold_idx",   64'(res_idx),   64'(hold_idx));
            end
            hold_pend = res_valid && !res_ready;
            hold_data = res_data;
            hold_idx  = res_idx;
            if (res_valid && res_ready) begin
                q_res_cyc.push_back(rel);
                q_res_data.push_back(res_data);
                q_res_idx.push_back(int'(res_idx));
            end
            if (sv_rd_en) q_rd.push_back(rel);
            if (busy)     q_busy.push_back(rel);
            if (done) begin
                q_done.push_back(rel);
`ifdef SVM_SCORE_MAX_EN
                done_max_data = max_data;
                done_max_idx  = max_idx;
`endif
            end
        end
    end

    task automatic clear_logs();
        q_res_cyc.delete(); q_res_data.delete(); q_res_idx.delete();
        q_rd.delete(); q_busy.delete(); q_done.delete();
    endtask

    // mode 0: always ready; 1: random ready; 2: ready low in cycles 5..8.
    function automatic logic rdy(input int c, input int mode);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(c >= 5 && c <= 8);
        return 1'b1;
    endfunction

    task automatic do_run(input int num, input int mode, input int restart_c);
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_sv = N_W'(num); t0 = cyc; res_ready = rdy(0, mode);
        for (int c = 1; c < 2000; c++) begin
            @(posedge clk); #1;
            start     = (c == restart_c);
            num_sv    = N_W'($urandom_range(0, 31));
            res_ready = rdy(c, mode);
            if (q_done.size() != 0) break;
        end
        start = 1'b0; res_ready = 1'b1;
    endtask

    task automatic check_run(input string tag, input int num, input int shift, input bit timing);
        int n;
        int last_hs;
        logic [ACC_W-1:0] best;
        int best_i;
        n = (num > NUM_SV) ? NUM_SV : num;
        chk({tag, "_res_cnt"}, 64'(q_res_data.size()), 64'(n));
        chk({tag, "_done_cnt"}, 64'(q_done.size()), 64'd1);
        chk({tag, "_rd_cnt"}, 64'(q_rd.size()), 64'(n));
        best = '0; best_i = 0; last_hs = 0;
        for (int k = 0; k < n && k < q_res_data.size(); k++) begin
            chk({tag, "_data"}, 64'(q_res_data[k]), 64'(dot(mem[k])));
            chk({tag, "_idx"},  64'(q_res_idx[k]),  64'(k));
            if (timing) chk({tag, "_res_cyc"}, 64'(q_res_cyc[k]), 64'(PERIOD * (k + 1) + shift));
            if (k == 0 || dot(mem[k]) > best) begin best = dot(mem[k]); best_i = k; end
            last_hs = q_res_cyc[k];
        end
        if (timing) begin
            for (int k = 0; k < n && k < q_rd.size(); k++)
                chk({tag, "_rd_cyc"}, 64'(q_rd[k]), 64'(1 + PERIOD * k + ((k > 0) ? shift : 0)));
            chk({tag, "_busy_len"}, 64'(q_busy.size()), 64'((n == 0) ? 0 : PERIOD * n + shift));
            if (n > 0 && q_busy.size() > 0) chk({tag, "_busy_first"}, 64'(q_busy[0]), 64'd1);
        end
        if (q_done.size() == 1) begin
            chk({tag, "_done_cyc"}, 64'(q_done[0]), 64'((n == 0) ? 1 : last_hs + 1));
`ifdef SVM_SCORE_MAX_EN
            chk({tag, "_max_data"}, 64'(done_max_data), 64'(best));
            chk({tag, "_max_idx"},  64'(done_max_idx),  64'(best_i));
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_sv = '0; res_ready = 1'b1;
        for (int p = 0; p < NUM_OF_PIXELS; p++) xv[p] = 2;
        for (int k = 0; k < NUM_SV; k++) mem[k] = splat(k + 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({busy, done, sv_rd_en, dp_valid, res_valid}), 64'd0);
        chk("reset_data", 64'({res_data, res_idx, sv_rd_addr}), 64'd0);
        chk("reset_xsv",  64'(|dp_x_sv), 64'd0);
        rst_n = 1'b1;

        // Basic: scores 60*(k+1), results at cycles 5/10/15, done at 16.
        do_run(3, 0, 0);
        check_run("basic", 3, 0, 1'b1);
        // Backpressure on the first result shifts everything after it by 4.
        do_run(3, 2, 0);
        check_run("bp", 3, 4, 1'b1);
        do_run(0, 0, 0);
        check_run("zero", 0, 0, 1'b1);
        do_run(20, 0, 0);
        check_run("clamp", 20, 0, 1'b1);
        // A second start mid-run must not disturb the run in progress.
        do_run(3, 0, 7);
        check_run("restart", 3, 0, 1'b1);

        // Reset during the wait window of SV 1 (cycles 8-9).
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; num_sv = N_W'(3); t0 = cyc;
        repeat (8) begin @(posedge clk); #1; start = 1'b0; end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({busy, done, sv_rd_en, dp_valid, res_valid}), 64'd0);
        chk("midrst_data", 64'({res_data, res_idx, sv_rd_addr}), 64'd0);
        chk("midrst_xsv",  64'(|dp_x_sv), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_done", 64'(q_done.size()), 64'd0);
        chk("midrst_res_cnt", 64'(q_res_data.size()), 64'd1);
        chk("midrst_rd_cnt",  64'(q_rd.size()), 64'd2);
        do_run(3, 0, 0);
        check_run("after_rst", 3, 0, 1'b1);

        // Scores 50, 90, 90, 10: the tie keeps index 1.
        mem[0] = '0; mem[0][7:0] = 8'd25;
        mem[1] = '0; mem[1][7:0] = 8'd45;
        mem[2] = '0; mem[2][7:0] = 8'd45;
        mem[3] = '0; mem[3][7:0] = 8'd5;
        do_run(4, 0, 0);
        check_run("maxrun", 4, 0, 1'b1);
`ifdef SVM_SCORE_MAX_EN
        chk("max_90_data", 64'(done_max_data), 64'd90);
        chk("max_90_idx",  64'(done_max_idx),  64'd1);
`endif

        // Randomized runs: random memory, test vector, count and backpressure.
        for (int r = 0; r < 6; r++) begin
            int num;
            for (int p = 0; p < NUM_OF_PIXELS; p++) xv[p] = $urandom_range(0, 255);
            for (int k = 0; k < NUM_SV; k++) mem[k] = rand_vec();
            num = $urandom_range(0, 20);
            do_run(num, 1, 0);
            check_run("rand", num, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/svm_dot_sched.md
Name: svm_dot_sched

Overview:
- Sequences one test vector against up to NUM_SV stored support vectors through the shared dot-product datapath.
- Fetches each SV word from SV memory, presents it to the datapath, waits the datapath latency, captures the score and streams it out with a valid/ready handshake.
- Sits between the SV ROM/BRAM and the dot-product unit, upstream of the SVM decision/kernel stage.

Parameters:
- XLEN_PIXEL, 8, bits per pixel.
- NUM_OF_PIXELS, 30, pixels per vector.
- NUM_SV, 16, maximum support vectors per run.
- SV_ADDR_W, 4, SV memory address width (clog2 NUM_SV).
- ACC_W, 32, dot-product result width (4*XLEN_PIXEL).
- DP_LAT, 2, datapath latency in cycles from dp_valid to a valid dp_result (>=1).

Ports:
- clk, in, 1, clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, run request; sampled only in IDLE.
- num_sv, in, SV_ADDR_W+1, SVs this run; sampled with start.
- busy, out, 1, high from the cycle after start is accepted until done.
- done, out, 1, one-cycle pulse after the last result is accepted.
- sv_rd_en, out, 1, SV memory read strobe.
- sv_rd_addr, out, SV_ADDR_W, SV memory address.
- sv_rd_data, in, NUM_OF_PIXELS*XLEN_PIXEL, SV word; valid exactly one cycle after sv_rd_en.
- dp_x_sv, out, NUM_OF_PIXELS*XLEN_PIXEL, registered SV vector to the datapath.
- dp_valid, out, 1, one-cycle pulse when dp_x_sv updates.
- dp_result, in, ACC_W, datapath score.
- res_valid, out, 1, result available.
- res_ready, in, 1, consumer accepts.
- res_data, out, ACC_W, captured score.
- res_idx, out, SV_ADDR_W, SV index of res_data.

Behaviour:
- Reset: asynchronous, active-low. All outputs, dp_x_sv, and counters are 0; FSM goes to IDLE. Reset asserted mid-run aborts immediately, and no done is issued.
- FSM: IDLE -> FETCH -> LOAD -> WAIT -> EMIT -> (FETCH | FIN) -> IDLE.
- IDLE:
  - start=1 with num_sv!=0 latches n = min(num_sv, NUM_SV), clears idx, and goes to FETCH.
  - start=1 with num_sv=0 goes to FIN; done pulses with no results.
- FETCH (1 cycle): sv_rd_en=1, sv_rd_addr=idx.
- LOAD (1 cycle): dp_x_sv <= sv_rd_data, dp_valid pulses next cycle, wait counter loads DP_LAT.
- WAIT (DP_LAT cycles): decrement the counter. On the final cycle, res_data <= dp_result and res_idx <= idx.
- EMIT: res_valid=1, with res_data and res_idx held stable until res_valid&res_ready.
  - On handshake, if idx==n-1, go to FIN.
  - Otherwise idx <= idx+1 and go to FETCH.
- FIN (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- Latency: with the start edge as cycle 0, first res_valid appears in cycle DP_LAT+3. With res_ready held high, the period is DP_LAT+3 cycles per SV.
- start while busy is ignored. sv_rd_en is never asserted outside FETCH. res_valid never drops without a handshake.
- x_test is not handled here; the datapath owner holds it stable while busy.
- idx never wraps. num_sv > NUM_SV is clamped.

Optional Feature:
- Macro: SVM_SCORE_MAX_EN.
- Defined:
  - Adds outputs max_data (ACC_W) and max_idx (SV_ADDR_W).
  - Both clear to 0 on reset and on accepted start.
  - On each res handshake they update if res_data > max_data (unsigned), or if it is the first result of the run. Ties keep the lower index.
  - Final values are stable when done pulses.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Basic run:
  - Stimulus: memory word k has all pixels = k+1; the DP model returns 60*(k+1) after DP_LAT=2; num_sv=3; res_ready=1; start in cycle 0.
  - Required response: res_valid in cycles 5, 10, 15 with data 60/120/180, idx 0/1/2; done in cycle 16; busy high cycles 1-15.
- Backpressure:
  - Stimulus: same run, res_ready low for 4 cycles at the first result.
  - Required response: res_data=60 and res_idx=0 held stable; no sv_rd_en until the handshake; remaining timing shifts by 4.
- Zero/clamp:
  - Stimulus: num_sv=0.
  - Required response: done one cycle after start, with no res_valid and no sv_rd_en.
  - Stimulus: num_sv=20.
  - Required response: exactly 16 results, idx 0..15.
- Start ignored:
  - Stimulus: pulse start again mid-run.
  - Required response: result count and timing are unchanged, with no second run.
- Reset mid-run:
  - Stimulus: rst low during WAIT of SV 1.
  - Required response: all outputs 0 asynchronously; no done. A fresh start then yields idx 0 first.
- SVM_SCORE_MAX_EN:
  - Stimulus: scores 50, 90, 90, 10.
  - Required response: at done, max_data=90 and max_idx=1.
